// File: rtl/regfile_pkg.sv
// Shared definitions for the MIPS general-purpose register file.
//
// Contents:
//   WORD_W, REGS     - default word width and entry count.
//   ZERO, SP, RA     - named MIPS register indices.
//   byte_merge()     - byte-granular merge used by the write path and by the bypass path,
//                      so that a bypassed read and the word stored on the edge never differ.
package regfile_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REGS   = 32;

    localparam int unsigned ZERO = 0;
    localparam int unsigned SP   = 29;
    localparam int unsigned RA   = 31;

    // byte_merge works on a fixed wide container; callers zero-extend their operands and
    // truncate the result back to their own width. MERGE_W bounds the largest WIDTH allowed.
    localparam int unsigned MERGE_W = 1024;
    localparam int unsigned MERGE_B = MERGE_W / 8;

    // Byte i of the result comes from new_word where mask[i] is set, else from old_word.
    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0] old_word,
        input logic [MERGE_W-1:0] new_word,
        input logic [MERGE_B-1:0] mask
    );
        logic [MERGE_W-1:0] result;
        result = old_word;
        for (int i = 0; i < int'(MERGE_B); i++) begin
            if (mask[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/register_word.sv
// One WIDTH-bit register-file entry: the enabled register generalised to per-byte enables.
//
// Ports:
//   clk  - clock; the entry updates on the rising edge.
//   rst  - asynchronous active-high reset; clears the entry to 0.
//   be   - per-byte write enable; bit i loads d[8i+7:8i]. All-zero holds the value.
//   d    - write data.
//   q    - current stored value.
module register_word
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH/8-1:0] be,
    input  logic [WIDTH-1:0]   d,
    output logic [WIDTH-1:0]   q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (|be) begin
            q <= WIDTH'(byte_merge(MERGE_W'(q), MERGE_W'(d), MERGE_B'(be)));
        end
    end

endmodule

// File: rtl/register_file.sv
// MIPS general-purpose register file: DEPTH words of WIDTH bits, one synchronous
// byte-enabled write port and two combinational read ports (A = rs, B = rt).
//
// Parameters:
//   WIDTH    - data width in bits, multiple of 8.
//   DEPTH    - number of entries, need not be a power of two.
//   ADDR_W   - address width, derived from DEPTH.
//   ZERO_REG - 1: entry 0 reads 0 and ignores writes (no storage is built for it).
//   BYPASS   - 1: a read of the address being written returns the merged write data
//              combinationally, before the edge.
//
// Ports:
//   Clk        - clock; writes on the rising edge.
//   Rst        - asynchronous active-high reset; clears every entry, forces reads to 0.
//   En         - write enable.
//   EndW       - write address; addresses >= DEPTH are dropped.
//   DadoW      - write data.
//   ByteEn     - per-byte write mask; bit i covers DadoW[8i+7:8i].
//   EndA, EndB - read addresses; addresses >= DEPTH read 0.
//   SaidaA/B   - read data.
module register_file
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = WORD_W,
    parameter int unsigned DEPTH    = REGS,
    parameter int unsigned ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               En,
    input  logic [ADDR_W-1:0]  EndW,
    input  logic [WIDTH-1:0]   DadoW,
    input  logic [WIDTH/8-1:0] ByteEn,
    input  logic [ADDR_W-1:0]  EndA,
    input  logic [ADDR_W-1:0]  EndB,
    output logic [WIDTH-1:0]   SaidaA,
    output logic [WIDTH-1:0]   SaidaB
);

    localparam int unsigned NB = WIDTH / 8;

    // One extra bit so the range check also works when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    if ((WIDTH % 8) != 0 || WIDTH == 0) begin : g_bad_width
        $error("register_file: WIDTH must be a nonzero multiple of 8");
    end
    if (WIDTH > MERGE_W) begin : g_too_wide
        $error("register_file: WIDTH exceeds regfile_pkg::MERGE_W");
    end

    logic             wr_legal;
    logic [WIDTH-1:0] words [DEPTH];
    logic [WIDTH-1:0] stored_a;
    logic [WIDTH-1:0] stored_b;
    logic [WIDTH-1:0] merged_a;
    logic [WIDTH-1:0] merged_b;
    logic             hit_a;
    logic             hit_b;

    // Rst is part of the qualifier so a reset rising mid-cycle aborts the write and
    // also suppresses the bypass.
    assign wr_legal = En && !Rst
                      && ({1'b0, EndW} < DEPTH_X)
                      && !((ZERO_REG != 0) && (EndW == '0));

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_entry
        if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
            assign words[i] = '0;
        end else begin : g_reg
            logic [NB-1:0] be_i;

            assign be_i = (wr_legal && (EndW == ADDR_W'(i))) ? ByteEn : '0;

            register_word #(
                .WIDTH (WIDTH)
            ) u_word (
                .clk (Clk),
                .rst (Rst),
                .be  (be_i),
                .d   (DadoW),
                .q   (words[i])
            );
        end
    end

    // Compare-and-select read mux: an address with no matching entry (>= DEPTH) reads 0
    // without ever indexing past the array.
    always_comb begin
        stored_a = '0;
        stored_b = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (EndA == ADDR_W'(i)) begin
                stored_a = words[i];
            end
            if (EndB == ADDR_W'(i)) begin
                stored_b = words[i];
            end
        end
    end

    always_comb begin
        merged_a = WIDTH'(byte_merge(MERGE_W'(stored_a), MERGE_W'(DadoW), MERGE_B'(ByteEn)));
        merged_b = WIDTH'(byte_merge(MERGE_W'(stored_b), MERGE_W'(DadoW), MERGE_B'(ByteEn)));
        // wr_legal already excludes entry 0 under ZERO_REG, so address 0 never bypasses.
        hit_a    = (BYPASS != 0) && wr_legal && (EndA == EndW);
        hit_b    = (BYPASS != 0) && wr_legal && (EndB == EndW);
    end

    always_comb begin
        SaidaA = '0;
        SaidaB = '0;
        if (!Rst) begin
            SaidaA = hit_a ? merged_a : stored_a;
            SaidaB = hit_b ? merged_b : stored_b;
        end
    end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    logic        Clk;
    logic        Rst;
    logic        En;
    logic [4:0]  EndW;
    logic [31:0] DadoW;
    logic [3:0]  ByteEn;
    logic [4:0]  EndA;
    logic [4:0]  EndB;
    logic [31:0] sa, sb, sa_nb, sb_nb, sa24, sb24;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem   [32];
    logic [31:0] mem24 [24];

    register_file dut (
        .Clk(Clk), .Rst(Rst), .En(En), .EndW(EndW), .DadoW(DadoW), .ByteEn(ByteEn),
        .EndA(EndA), .EndB(EndB), .SaidaA(sa), .SaidaB(sb)
    );

    register_file #(.BYPASS(0)) dut_nb (
        .Clk(Clk), .Rst(Rst), .En(En), .EndW(EndW), .DadoW(DadoW), .ByteEn(ByteEn),
        .EndA(EndA), .EndB(EndB), .SaidaA(sa_nb), .SaidaB(sb_nb)
    );

    register_file #(.DEPTH(24)) dut24 (
        .Clk(Clk), .Rst(Rst), .En(En), .EndW(EndW), .DadoW(DadoW), .ByteEn(ByteEn),
        .EndA(EndA), .EndB(EndB), .SaidaA(sa24), .SaidaB(sb24)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge_m(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic clear_models();
        for (int i = 0; i < 32; i++) mem[i] = '0;
        for (int i = 0; i < 24; i++) mem24[i] = '0;
    endtask

    task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        if (a != 5'd0) begin
            mem[int'(a)] = merge_m(mem[int'(a)], d, be);
            if (a < 5'd24) mem24[int'(a)] = merge_m(mem24[int'(a)], d, be);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        En = 1'b1; EndW = a; DadoW = d; ByteEn = be;
        @(posedge Clk); #1;
        En = 1'b0;
        model_write(a, d, be);
    endtask

    task automatic sweep(input string tag);
        logic [31:0] e24;
        for (int i = 0; i < 32; i++) begin
            EndA = 5'(i);
            EndB = 5'(31 - i);
            #1;
            e24 = (i < 24) ? mem24[i] : 32'h0;
            check($sformatf("%s_a%0d", tag, i), sa, mem[i]);
            check($sformatf("%s_b%0d", tag, 31 - i), sb, mem[31 - i]);
            check($sformatf("%s_nb%0d", tag, i), sa_nb, mem[i]);
            check($sformatf("%s_d24_%0d", tag, i), sa24, e24);
        end
    endtask

    initial begin
        Rst = 1'b1; En = 1'b0; EndW = '0; DadoW = '0; ByteEn = '0; EndA = 5'd3; EndB = 5'd4;
        clear_models();
        #2;
        check("rst_init_a", sa, 32'h0);
        check("rst_init_b", sb, 32'h0);
        #10;
        Rst = 1'b0;
        #1;
        check("post_rst_a", sa, 32'h0);

        // Nonzero contents before the reset pulse.
        wr(5'd1, 32'h11111111, 4'hF);
        wr(5'd2, 32'h22222222, 4'hF);
        wr(5'(regfile_pkg::SP), 32'hDEADBEEF, 4'hF);
        EndA = 5'd29; EndB = 5'd2;
        #1;
        check("sp_written", sa, 32'hDEADBEEF);
        check("r2_written", sb, 32'h22222222);
        check("sp_oob_d24", sa24, 32'h0);

        // Reset pulse at t=50 for 150 ns.
        #(64'd50 - $time);
        Rst = 1'b1;
        clear_models();
        sweep("rst_hold");
        En = 1'b1; EndW = 5'd2; DadoW = 32'hFFFFFFFF; ByteEn = 4'hF; EndA = 5'd2;
        #1;
        check("rst_no_bypass", sa, 32'h0);
        @(posedge Clk); #1;
        check("rst_write_blocked", sa, 32'h0);
        En = 1'b0;
        #(64'd200 - $time);
        Rst = 1'b0;
        #1;
        check("rst_after_r2", sa, 32'h0);
        sweep("rst_after");

        // Basic write/read.
        wr(5'd5, 32'd15, 4'hF);
        DadoW = 32'd20; EndA = 5'd5;
        #1;
        check("basic_now", sa, 32'd15);
        @(posedge Clk); #1;
        check("basic_hold1", sa, 32'd15);
        @(posedge Clk); #1;
        check("basic_hold2", sa, 32'd15);

        // Byte enables.
        wr(5'd7, 32'hAABBCCDD, 4'hF);
        wr(5'd7, 32'h11223344, 4'b0101);
        EndA = 5'd7; EndB = 5'd7;
        #1;
        check("byte_en_a", sa, 32'hAA22CC44);
        check("byte_en_b", sb, 32'hAA22CC44);
        wr(5'd7, 32'hFFFFFFFF, 4'b0000);
        check("byte_en_zero", sa, 32'hAA22CC44);

        // Zero register.
        En = 1'b1; EndW = 5'd0; DadoW = 32'hFFFFFFFF; ByteEn = 4'hF; EndA = 5'd0; EndB = 5'd0;
        #1;
        check("zero_pre_a", sa, 32'h0);
        check("zero_pre_b", sb, 32'h0);
        @(posedge Clk); #1;
        En = 1'b0;
        check("zero_post_a", sa, 32'h0);
        check("zero_post_b", sb, 32'h0);
        check("zero_post_nb", sa_nb, 32'h0);

        // Bypass and dual port.
        wr(5'd9, 32'h00000001, 4'hF);
        EndA = 5'd9; EndB = 5'd9;
        En = 1'b1; EndW = 5'd9; DadoW = 32'h0000BEEF; ByteEn = 4'b0011;
        #1;
        check("byp_a", sa, 32'h0000BEEF);
        check("byp_b", sb, 32'h0000BEEF);
        check("byp_d24", sa24, 32'h0000BEEF);
        check("nobyp_pre_a", sa_nb, 32'h00000001);
        check("nobyp_pre_b", sb_nb, 32'h00000001);
        @(posedge Clk); #1;
        En = 1'b0;
        model_write(5'd9, 32'h0000BEEF, 4'b0011);
        check("nobyp_post_a", sa_nb, 32'h0000BEEF);
        check("nobyp_post_b", sb_nb, 32'h0000BEEF);
        En = 1'b1; DadoW = 32'hCAFE1234; ByteEn = 4'b1100;
        #1;
        check("byp_merge_a", sa, 32'hCAFEBEEF);
        check("byp_merge_nb", sa_nb, 32'h0000BEEF);
        @(posedge Clk); #1;
        En = 1'b0;
        model_write(5'd9, 32'hCAFE1234, 4'b1100);
        check("merge_stored", sa_nb, 32'hCAFEBEEF);

        // Return-address register and out-of-range write on DEPTH=24.
        wr(5'(regfile_pkg::RA), 32'h00400020, 4'hF);
        En = 1'b1; EndW = 5'd30; DadoW = 32'h5; ByteEn = 4'hF; EndA = 5'd30;
        #1;
        check("oob_pre_d24", sa24, 32'h0);
        check("oob_pre_d32", sa, 32'h5);
        @(posedge Clk); #1;
        En = 1'b0;
        model_write(5'd30, 32'h5, 4'hF);
        check("oob_post_d24", sa24, 32'h0);
        check("oob_post_d32", sa, 32'h5);
        sweep("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
